// File: rtl/shift_seq_pkg.sv
// Shared types and widths for the shift sequencer: FSM encoding, operand and amount widths.
package shift_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned AMT_W  = 2;

  localparam logic [AMT_W-1:0] AMT_LAST = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Shifter issue/result port and result stream handshake of the shift sequencer.
interface shift_seq_if;
  import shift_seq_pkg::*;

  logic [DATA_W-1:0] sh_data;
  logic [AMT_W-1:0]  sh_amt;
  logic              sh_valid;
  logic [DATA_W-1:0] sh_result;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output sh_data,
    output sh_amt,
    output sh_valid,
    output out_data,
    output out_valid,
    input  sh_result,
    input  out_ready
  );

  modport slave (
    input  sh_data,
    input  sh_amt,
    input  sh_valid,
    input  out_data,
    input  out_valid,
    output sh_result,
    output out_ready
  );

endinterface

// File: rtl/shift_seq_fifo.sv
// Small result FIFO (power-of-two depth) with synchronous active-low reset and occupancy count.
module shift_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic            o_full,
  output logic            o_empty,
  output logic [CntW-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // Empty FIFO presents zero so the stream output is clean after reset.
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Issues amounts 0..3 of a latched operand to an external shifter and streams results via a FIFO.
// Optional macro SHIFT_SEQ_LEVEL_EN adds a FIFO occupancy output 'level'.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
`ifdef SHIFT_SEQ_LEVEL_EN
  output logic [2:0]        level,
`endif
  shift_seq_if.master       bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_operand;
  logic [AMT_W-1:0]  r_amt;
  logic              r_done;

  logic              w_issue;
  logic              w_full;
  logic              w_empty;
  logic [CntW-1:0]   w_count;
  logic [DATA_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_last_pop;

  assign w_issue = (r_state == StIssue);

  // Fullness is the registered count, so a same-cycle pop never unblocks an issue.
  assign bus.sh_valid  = w_issue && !w_full;
  assign bus.sh_data   = w_issue ? r_operand : '0;
  assign bus.sh_amt    = w_issue ? r_amt : '0;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head;

  assign w_push     = ena && bus.sh_valid;
  assign w_pop      = ena && bus.out_valid && bus.out_ready;
  assign w_last_pop = w_pop && !w_push && (w_count == CntW'(1));

  assign busy = (r_state != StIdle);
  assign done = r_done;

`ifdef SHIFT_SEQ_LEVEL_EN
  assign level = 3'(w_count);
`endif

  shift_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.sh_result),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_operand <= '0;
      r_amt     <= '0;
      r_done    <= 1'b0;
    end else begin
      // done is a single-cycle pulse even if ena drops right after it.
      r_done <= 1'b0;
      if (ena) begin
        unique case (r_state)
          StIdle: begin
            if (start) begin
              r_operand <= data_in;
              r_amt     <= '0;
              r_state   <= StIssue;
            end
          end
          StIssue: begin
            if (w_push) begin
              if (r_amt == AMT_LAST) r_state <= StDrain;
              else                   r_amt   <= r_amt + AMT_W'(1);
            end
          end
          StDrain: begin
            if (w_empty || w_last_pop) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result-FIFO entries; legal values 2 or 4 only.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port ena, input, 1, global enable; when 0, all state holds and no push/pop occurs.
REQ-005 SHALL have port start, input, 1, request to begin a sequence; sampled only in IDLE.
REQ-006 SHALL have port data_in, input, 4, operand latched on accepted start.
REQ-007 SHALL have ports sh_data (output, 4), sh_amt (output, 2) and sh_valid (output, 1): operand, shift amount and issue-valid driven to the combinational barrel shifter.
REQ-008 SHALL have port sh_result, input, 4, shifter output for the current sh_data/sh_amt, valid in the same cycle.
REQ-009 SHALL have ports out_data (output, 4), out_valid (output, 1) and out_ready (input, 1): result stream, valid/ready handshake.
REQ-010 SHALL have ports busy (output, 1), high whenever state is not IDLE, and done (output, 1), a one-cycle pulse on return to IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-012 SHALL, in IDLE with start=1 and ena=1, latch data_in, clear the amount counter to 0 and enter ISSUE next cycle.
REQ-013 SHALL ignore start in ISSUE and DRAIN (no relatch, no restart).
REQ-014 SHALL, in ISSUE, drive sh_data = latched operand, sh_amt = counter and sh_valid = (FIFO not full).
REQ-015 SHALL, on a cycle with sh_valid=1, push sh_result into the FIFO and increment the counter; latency from issue to FIFO head visibility is 1 cycle.
REQ-016 SHALL stall the issue (counter holds, no push) while the FIFO is full at the start of the cycle, even if a pop occurs that cycle.
REQ-017 SHALL move ISSUE->DRAIN in the cycle after amount 3 is pushed; the counter does not wrap.
REQ-018 SHALL move DRAIN->IDLE when the FIFO becomes empty, asserting done for exactly that transition cycle.
REQ-019 SHALL present the FIFO head on out_data with out_valid = (FIFO not empty); a pop occurs when out_valid and out_ready are both 1.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL produce results strictly in amount order 0,1,2,3, with exactly 4 results per sequence.
REQ-022 SHALL hold sh_valid=0, and sh_data/sh_amt at 0, outside ISSUE.

Reset
REQ-023 SHALL, when rst_n=0 at a rising clk, enter IDLE, empty the FIFO, and zero the counter and latched operand.
REQ-024 SHALL drive sh_data=0, sh_amt=0, sh_valid=0, out_data=0, out_valid=0, busy=0 and done=0 after reset.
REQ-025 SHALL discard any in-flight sequence and queued results on a reset mid-operation, with no done pulse.

Configuration
REQ-026 SHALL, when macro SHIFT_SEQ_LEVEL_EN is defined, add output port level (3 bits) giving the current FIFO occupancy 0..FIFO_DEPTH, with reset value 0.
REQ-027 SHALL, without SHIFT_SEQ_LEVEL_EN, omit the level port; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state encoding, the operand width (4) and the amount width (2) in the shared package shift_seq_pkg.
REQ-029 SHALL implement the FIFO as sub-module shift_seq_fifo (push, pop, full, empty, count), instantiated once.
REQ-030 SHALL contain no barrel-shift logic of its own; the shifter remains external.

Verification (bench models the shifter as rotate-left)
REQ-031 SHALL pass: start with data_in=4'b1001, out_ready=1 -> out_data sequence 1001, 0011, 0110, 1100, then a done pulse, then busy=0.
REQ-032 SHALL pass: same stimulus, out_ready=0 for 10 cycles -> at most FIFO_DEPTH pushes, sh_valid=0 while full, out_data held at 1001; on release, all 4 results arrive in order.
REQ-033 SHALL pass: start pulsed again during ISSUE with data_in=4'b0001 -> ignored; results still derived from 4'b1001.
REQ-034 SHALL pass: rst_n=0 after 2 results are pushed -> next cycle IDLE, out_valid=0, no done; a fresh start runs normally.
REQ-035 SHALL pass: ena=0 mid-ISSUE for 3 cycles -> counter, FIFO and outputs frozen; the sequence completes correctly afterwards.
REQ-036 SHALL pass, with SHIFT_SEQ_LEVEL_EN defined and out_ready=0: level steps 0,1,2,3,4 and then holds at 4.
